// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential signed divider:
//   - W_DEFAULT : default operand width (16 bits)
//   - state_t   : FSM state word type
//   - ST_*      : FSM state encodings (IDLE, CALC, FIX, DONE)
// -----------------------------------------------------------------------------
package div_pkg;

   localparam int W_DEFAULT = 16;

   localparam int STATE_W = 2;
   typedef logic [STATE_W-1:0] state_t;

   localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
   localparam logic [STATE_W-1:0] ST_CALC = 2'd1;
   localparam logic [STATE_W-1:0] ST_FIX  = 2'd2;
   localparam logic [STATE_W-1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational iteration of unsigned restoring division.
// The partial remainder is shifted left by one, the next dividend bit is
// brought in, and the divisor is subtracted when it fits.
// Ports:
//   rem_i  : current partial remainder (always < dvs_i)
//   bit_i  : next dividend bit, MSB first
//   dvs_i  : divisor magnitude (non-zero)
//   rem_o  : next partial remainder
//   qbit_o : quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step
   import div_pkg::*;
#(
   parameter int w = W_DEFAULT
) (
   input  logic [w-1:0] rem_i,
   input  logic         bit_i,
   input  logic [w-1:0] dvs_i,
   output logic [w-1:0] rem_o,
   output logic         qbit_o
);

   logic [w:0] shifted_s;

   // Trial subtraction; one extra bit holds the shifted-out remainder MSB.
   // The result is below the divisor, so a w-bit subtract is exact.
   always_comb begin
      shifted_s = {rem_i, bit_i};
      if (shifted_s >= {1'b0, dvs_i}) begin
         qbit_o = 1'b1;
         rem_o  = shifted_s[w-1:0] - dvs_i;
      end else begin
         qbit_o = 1'b0;
         rem_o  = shifted_s[w-1:0];
      end
   end

endmodule

// File: rtl/seq_div.sv
// -----------------------------------------------------------------------------
// seq_div
// Sequential signed divider: x = q*y + r, quotient truncated toward zero,
// remainder carries the sign of x. Magnitudes are divided with w restoring
// steps (one per cycle), then signs are applied in a single fix-up cycle.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   start : request a division (sampled only in IDLE)
//   x, y  : signed dividend / divisor, captured on the accepting edge
//   q, r  : signed quotient / remainder, held until the next load
//   busy  : high from the cycle after accept until done
//   done  : one-cycle pulse when q/r/dz/ovf are valid
//   dz    : divide by zero (q = all ones, r = x)
//   ovf   : most-negative / -1 (q wraps to most-negative)
// -----------------------------------------------------------------------------
module seq_div
   import div_pkg::*;
#(
   parameter int w = W_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [w-1:0] x,
   input  logic [w-1:0] y,
   output logic [w-1:0] q,
   output logic [w-1:0] r,
   output logic         busy,
   output logic         done,
   output logic         dz,
   output logic         ovf
);

   localparam int               CNT_W     = $clog2(w) + 1;
   localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(w - 1);
   localparam logic [w-1:0]     ONE_W     = {{(w-1){1'b0}}, 1'b1};
   localparam logic [w-1:0]     ZERO_W    = {w{1'b0}};
   localparam logic [w-1:0]     ALL_ONES  = {w{1'b1}};
   localparam logic [w-1:0]     MOST_NEG  = {1'b1, {(w-1){1'b0}}};

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [w-1:0]     x_q,     x_d;
   logic [w-1:0]     y_q,     y_d;
   logic             sx_q,    sx_d;
   logic             sy_q,    sy_d;
   logic [w-1:0]     rem_q,   rem_d;
   logic [w-1:0]     dvd_q,   dvd_d;   // |x| shifts out MSB-first, quotient shifts in
   logic [w-1:0]     dvs_q,   dvs_d;
   logic [w-1:0]     q_q,     q_d;
   logic [w-1:0]     r_q,     r_d;
   logic             busy_q,  busy_d;
   logic             done_q,  done_d;
   logic             dz_q,    dz_d;
   logic             ovf_q,   ovf_d;

   logic [w-1:0]     step_rem_s;
   logic             step_qbit_s;

   function automatic logic [w-1:0] neg2c(input logic [w-1:0] v);
      return ~v + ONE_W;
   endfunction

   // Magnitude of a two's-complement value; most-negative maps to 2^(w-1),
   // which is still representable as an unsigned w-bit value.
   function automatic logic [w-1:0] mag(input logic [w-1:0] v);
      if (v[w-1]) begin
         return neg2c(v);
      end else begin
         return v;
      end
   endfunction

   div_step #(
      .w (w)
   ) u_step (
      .rem_i  (rem_q),
      .bit_i  (dvd_q[w-1]),
      .dvs_i  (dvs_q),
      .rem_o  (step_rem_s),
      .qbit_o (step_qbit_s)
   );

   // Next-state and datapath update for the IDLE/CALC/FIX/DONE sequence.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      x_d     = x_q;
      y_d     = y_q;
      sx_d    = sx_q;
      sy_d    = sy_q;
      rem_d   = rem_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      q_d     = q_q;
      r_d     = r_q;
      dz_d    = dz_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               x_d   = x;
               y_d   = y;
               sx_d  = x[w-1];
               sy_d  = y[w-1];
               dvd_d = mag(x);
               dvs_d = mag(y);
               rem_d = ZERO_W;
               cnt_d = {CNT_W{1'b0}};
               dz_d  = 1'b0;
               ovf_d = 1'b0;
               if (y == ZERO_W) begin
                  // Divide by zero bypasses the iteration entirely.
                  state_d = ST_DONE;
                  q_d     = ALL_ONES;
                  r_d     = x;
                  dz_d    = 1'b1;
               end else begin
                  state_d = ST_CALC;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CALC: begin
            rem_d = step_rem_s;
            dvd_d = {dvd_q[w-2:0], step_qbit_s};
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == LAST_STEP) begin
               state_d = ST_FIX;
            end else begin
               state_d = ST_CALC;
            end
         end
         ST_FIX: begin
            if (sx_q ^ sy_q) begin
               q_d = neg2c(dvd_q);
            end else begin
               q_d = dvd_q;
            end
            if (sx_q) begin
               r_d = neg2c(rem_q);
            end else begin
               r_d = rem_q;
            end
            ovf_d   = (x_q == MOST_NEG) && (y_q == ALL_ONES);
            state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // done is registered from the DONE state, so it rises as busy falls.
      busy_d = (state_d != ST_IDLE);
      done_d = (state_q == ST_DONE);
   end

   // State, working and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= {CNT_W{1'b0}};
         x_q     <= ZERO_W;
         y_q     <= ZERO_W;
         sx_q    <= 1'b0;
         sy_q    <= 1'b0;
         rem_q   <= ZERO_W;
         dvd_q   <= ZERO_W;
         dvs_q   <= ZERO_W;
         q_q     <= ZERO_W;
         r_q     <= ZERO_W;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         y_q     <= y_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         rem_q   <= rem_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         q_q     <= q_d;
         r_q     <= r_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dz_q    <= dz_d;
         ovf_q   <= ovf_d;
      end
   end

   assign q    = q_q;
   assign r    = r_q;
   assign busy = busy_q;
   assign done = done_q;
   assign dz   = dz_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_div.sv
// -----------------------------------------------------------------------------
// tb_seq_div
// Self-checking bench for seq_div: directed corner cases plus randomized
// operands, compared against integer division in the bench.
// -----------------------------------------------------------------------------
module tb_seq_div;

   localparam int W = 16;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] x;
   logic [W-1:0] y;
   logic [W-1:0] q;
   logic [W-1:0] r;
   logic         busy;
   logic         done;
   logic         dz;
   logic         ovf;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] hold_q;
   logic [W-1:0] hold_r;

   seq_div #(
      .w (W)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .x     (x),
      .y     (y),
      .q     (q),
      .r     (r),
      .busy  (busy),
      .done  (done),
      .dz    (dz),
      .ovf   (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer division (truncating, remainder follows dividend).
   task automatic model(input logic [W-1:0] xv, input logic [W-1:0] yv,
                        output logic [W-1:0] eq, output logic [W-1:0] er,
                        output logic edz, output logic eovf);
      int xi;
      int yi;
      xi = $signed(xv);
      yi = $signed(yv);
      if (yi == 0) begin
         eq   = {W{1'b1}};
         er   = xv;
         edz  = 1'b1;
         eovf = 1'b0;
      end else begin
         eq   = W'(xi / yi);
         er   = W'(xi % yi);
         edz  = 1'b0;
         eovf = (xi == -(1 << (W - 1))) && (yi == -1);
      end
   endtask

   // One full transaction; inject_cyc > 0 pulses a stray start at that cycle.
   task automatic run_div(input logic [W-1:0] xv, input logic [W-1:0] yv, input int inject_cyc);
      logic [W-1:0] eq;
      logic [W-1:0] er;
      logic         edz;
      logic         eovf;
      int           cyc;
      int           busy_cnt;
      int           extra_done;
      model(xv, yv, eq, er, edz, eovf);
      @(negedge clk);
      x     = xv;
      y     = yv;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      x     = W'($urandom);
      y     = W'($urandom);
      cyc      = 1;
      busy_cnt = 0;
      if (yv != {W{1'b0}}) begin
         check_eq("hold_q", q, hold_q);
         check_eq("hold_r", r, hold_r);
         check_eq("flags_cleared", {dz, ovf}, 2'b00);
      end
      while (done !== 1'b1 && cyc < W + 20) begin
         if (busy === 1'b1) busy_cnt++;
         if (cyc == inject_cyc) begin
            x     = W'($urandom);
            y     = W'($urandom);
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      check_eq("done_seen", done, 1'b1);
      check_eq("latency", cyc, (yv == {W{1'b0}}) ? 2 : W + 3);
      check_eq("busy_cycles", busy_cnt, (yv == {W{1'b0}}) ? 1 : W + 2);
      check_eq("busy_at_done", busy, 1'b0);
      check_eq("q", q, eq);
      check_eq("r", r, er);
      check_eq("dz", dz, edz);
      check_eq("ovf", ovf, eovf);
      hold_q = eq;
      hold_r = er;
      @(negedge clk);
      check_eq("done_pulse_width", done, 1'b0);
      if (inject_cyc > 0) begin
         extra_done = 0;
         for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (done === 1'b1) extra_done++;
         end
         check_eq("no_extra_done", extra_done, 0);
         check_eq("q_after_ignore", q, eq);
      end
   endtask

   initial begin
      logic [W-1:0] rx;
      logic [W-1:0] ry;
      int           no_done;
      rst    = 1'b1;
      start  = 1'b0;
      x      = {W{1'b0}};
      y      = {W{1'b0}};
      hold_q = {W{1'b0}};
      hold_r = {W{1'b0}};
      repeat (3) @(negedge clk);
      check_eq("reset_outputs", {q, r, busy, done, dz, ovf}, {(2 * W + 4){1'b0}});
      rst = 1'b0;

      // Directed corner cases.
      run_div(16'd100,  16'd7,    0);
      run_div(16'hFF9C, 16'd7,    0);
      run_div(16'd100,  16'hFFF9, 0);
      run_div(16'd5,    16'd0,    0);
      run_div(16'h8000, 16'hFFFF, 0);
      run_div(16'd0,    16'd3,    0);
      run_div(16'h7FFF, 16'h8000, 0);
      run_div(16'd100,  16'd7,    3);

      // Reset in the middle of CALC aborts the operation.
      @(negedge clk);
      x     = 16'd100;
      y     = 16'd7;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      check_eq("rst_mid_calc", {q, r, busy, done, dz, ovf}, {(2 * W + 4){1'b0}});
      no_done = 0;
      repeat (3) begin
         @(negedge clk);
         if (done === 1'b1) no_done++;
      end
      check_eq("rst_no_done", no_done, 0);
      rst    = 1'b0;
      hold_q = {W{1'b0}};
      hold_r = {W{1'b0}};
      run_div(16'd100, 16'd7, 0);

      // Randomized operands with biased corner classes.
      for (int n = 0; n < 40; n++) begin
         rx = W'($urandom);
         ry = W'($urandom);
         case ($urandom_range(0, 7))
            0: ry = {W{1'b0}};
            1: ry = {W{1'b1}};
            2: ry = W'($urandom_range(1, 9));
            3: rx = 16'h8000;
            default: rx = rx;
         endcase
         repeat ($urandom_range(0, 2)) @(negedge clk);
         run_div(rx, ry, (n % 10 == 5) ? 3 : 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seq_div.md
SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 SHALL have parameter: w, 16, operand width in bits (even, >=4).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port: start  input  1  request a division; sampled only in IDLE.
REQ-005 SHALL have port: x  input  w  signed two's-complement dividend, captured on accepted start.
REQ-006 SHALL have port: y  input  w  signed two's-complement divisor, captured on accepted start.
REQ-007 SHALL have port: q  output  w  signed quotient.
REQ-008 SHALL have port: r  output  w  signed remainder.
REQ-009 SHALL have port: busy  output  1  high from the cycle after an accepted start until done.
REQ-010 SHALL have port: done  output  1  one-cycle pulse when q/r are valid.
REQ-011 SHALL have port: dz  output  1  divide-by-zero flag, valid with done.
REQ-012 SHALL have port: ovf  output  1  overflow flag (most-negative / -1), valid with done.

Function
REQ-013 SHALL implement the signed inverse of the team's radix-4 Booth multiplier: for y!=0, x = q*y + r, |r| < |y|.
REQ-014 SHALL truncate the quotient toward zero; r SHALL take the sign of x (r=0 allowed).
REQ-015 SHALL use the FSM states IDLE, CALC, FIX, DONE.
REQ-016 IDLE: start=1 SHALL capture x, y, the sign bits, and |x|, |y|; next state CALC; otherwise stay.
REQ-017 CALC SHALL perform one unsigned shift-subtract (restoring) step per cycle for exactly w cycles, using a log2(w)+1-bit counter, then go to FIX.
REQ-018 FIX SHALL negate the quotient magnitude if sign(x) xor sign(y), negate the remainder magnitude if sign(x), load q/r; next state DONE.
REQ-019 DONE SHALL assert done for exactly one cycle; next state IDLE.
REQ-020 Latency: start accepted at edge N -> done high in the cycle after edge N+w+2 (w+2 busy cycles), fixed for all non-zero divisors.
REQ-021 y=0: on accept SHALL go directly to DONE; q=all ones, r=x, dz=1; done one cycle after accept.
REQ-022 x=most-negative, y=-1: SHALL complete normally with q=most-negative (wrapped), r=0, ovf=1.
REQ-023 start while busy or in DONE SHALL be ignored, and captured operands SHALL NOT change.
REQ-024 q, r, dz, ovf SHALL hold their last values until the next FIX/DONE load; dz/ovf SHALL clear on the next accepted start.
REQ-025 Operand inputs SHALL be don't-care except at the accepting edge.

Reset
REQ-026 rst SHALL asynchronously force state IDLE; q=0, r=0, busy=0, done=0, dz=0, ovf=0; clear the counter and working registers.
REQ-027 rst during CALC/FIX SHALL abort the operation with no done pulse; the first start after rst release SHALL be accepted normally.

Structure
REQ-028 A shared package div_pkg SHALL hold the state enumeration and the default width constant (16).
REQ-029 One sub-module, div_step, SHALL implement a single combinational shift-subtract iteration (partial remainder, divisor -> next remainder, quotient bit); seq_div SHALL instantiate it once.
REQ-030 The total RTL SHALL fit in 120-400 lines; no multi-cycle paths, no latches.

Verification
REQ-031 x=100, y=7 -> after w+2 busy cycles, done=1, q=14 (0x000E), r=2, dz=0, ovf=0.
REQ-032 x=-100 (0xFF9C), y=7 -> q=0xFFF2 (-14), r=0xFFFE (-2); x=100, y=-7 -> q=0xFFF2, r=2.
REQ-033 x=5, y=0 -> done one cycle after accept, q=0xFFFF, r=5, dz=1.
REQ-034 x=0x8000, y=0xFFFF -> q=0x8000, r=0, ovf=1.
REQ-035 start pulsed with new operands at CALC cycle 3 -> ignored; result matches the first operands; exactly one done pulse.
REQ-036 rst asserted mid-CALC -> all outputs 0 immediately, no done; a subsequent 100/7 request yields q=14, r=2.
